// File: rtl/wb_stage.sv
// Writeback stage: M/W pipeline register, load-data extraction/merge and
// register-file write port drive, plus a retired-instruction counter.
module wb_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] LINK_OFFSET = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic        m_valid,
  input  logic        m_regwrite,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_wdsel,
  input  logic [2:0]  m_ldtype,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_mem,
  input  logic [31:0] m_rt_old,
  input  logic [31:0] m_pc,
  output logic [4:0]  WA,
  output logic [31:0] WD,
  output logic        WE,
  output logic [31:0] pc,
  output logic        w_valid,
  output logic [31:0] retired
);

  logic        valid_q, regwrite_q;
  logic [4:0]  wa_q;
  logic [1:0]  wdsel_q;
  logic [2:0]  ldtype_q;
  logic [31:0] alu_q, mem_q, rt_old_q, pc_q;
  logic [31:0] retired_q, retired_d;
  logic [31:0] wd_d;

  // Byte/halfword extraction and lwl/lwr merge with the captured old rt.
  function automatic logic [31:0] load_ext(input logic [2:0]  t,
                                           input logic [1:0]  l,
                                           input logic [31:0] mem,
                                           input logic [31:0] old);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = mem[{l, 3'b000} +: 8];
    h = l[1] ? mem[31:16] : mem[15:0];
    r = mem;
    case (t)
      3'd1: r = {24'h0, b};
      3'd2: r = {{24{b[7]}}, b};
      3'd3: r = {16'h0, h};
      3'd4: r = {{16{h[15]}}, h};
      3'd5: begin
        case (l)
          2'd0:    r = mem;
          2'd1:    r = {old[31:24], mem[31:8]};
          2'd2:    r = {old[31:16], mem[31:16]};
          default: r = {old[31:8],  mem[31:24]};
        endcase
      end
      3'd6: begin
        case (l)
          2'd0:    r = {mem[7:0],  old[23:0]};
          2'd1:    r = {mem[15:0], old[15:0]};
          2'd2:    r = {mem[23:0], old[7:0]};
          default: r = mem;
        endcase
      end
      default: r = mem;
    endcase
    return r;
  endfunction

  // The instruction in W leaves on any advancing or flushing edge.
  always_comb begin
    retired_d = retired_q;
    if (valid_q && (en || flush)) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wa_q       <= 5'd0;
      wdsel_q    <= 2'd0;
      ldtype_q   <= 3'd0;
      alu_q      <= 32'd0;
      mem_q      <= 32'd0;
      rt_old_q   <= 32'd0;
      pc_q       <= RESET_PC;
      retired_q  <= 32'd0;
    end else begin
      retired_q <= retired_d;
      if (flush) begin
        valid_q    <= 1'b0;
        regwrite_q <= 1'b0;
      end else if (en) begin
        valid_q    <= m_valid;
        regwrite_q <= m_regwrite;
        wa_q       <= m_wa;
        wdsel_q    <= m_wdsel;
        ldtype_q   <= m_ldtype;
        alu_q      <= m_alu;
        mem_q      <= m_mem;
        rt_old_q   <= m_rt_old;
        pc_q       <= m_pc;
      end
    end
  end

  // W stage: result selection is purely combinational from the W registers.
  always_comb begin
    wd_d = alu_q;
    case (wdsel_q)
      2'd1:    wd_d = load_ext(ldtype_q, alu_q[1:0], mem_q, rt_old_q);
      2'd2:    wd_d = pc_q + LINK_OFFSET;
      default: wd_d = alu_q;
    endcase
  end

  assign WE      = valid_q & regwrite_q & (wa_q != 5'd0);
  assign WA      = wa_q;
  assign WD      = wd_d;
  assign pc      = pc_q;
  assign w_valid = valid_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: spec-level model checked every cycle plus
// hand-computed literal expectations for the listed scenarios.
module tb_wb_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, en, flush;
  logic        m_valid, m_regwrite;
  logic [4:0]  m_wa;
  logic [1:0]  m_wdsel;
  logic [2:0]  m_ldtype;
  logic [31:0] m_alu, m_mem, m_rt_old, m_pc;
  logic [4:0]  WA;
  logic [31:0] WD, pc, retired;
  logic        WE, w_valid;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  wb_stage #(.RESET_PC(RST_PC), .LINK_OFFSET(32'd8)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .m_valid(m_valid), .m_regwrite(m_regwrite), .m_wa(m_wa),
    .m_wdsel(m_wdsel), .m_ldtype(m_ldtype), .m_alu(m_alu),
    .m_mem(m_mem), .m_rt_old(m_rt_old), .m_pc(m_pc),
    .WA(WA), .WD(WD), .WE(WE), .pc(pc), .w_valid(w_valid),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected write data from the architectural rules, using shifts and masks.
  function automatic logic [31:0] exp_wd(input logic [1:0] ws, input logic [2:0] lt,
                                         input logic [31:0] alu, input logic [31:0] mem,
                                         input logic [31:0] old, input logic [31:0] p);
    int          L;
    logic [31:0] b, h, r;
    L = int'(alu[1:0]);
    b = (mem >> (8 * L)) & 32'h0000_00FF;
    h = (mem >> (16 * (L / 2))) & 32'h0000_FFFF;
    if (ws == 2'd2) return p + 32'd8;
    if (ws != 2'd1) return alu;
    case (lt)
      3'd1: r = b;
      3'd2: r = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd3: r = h;
      3'd4: r = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd5: r = (mem >> (8 * L)) | (old & ~(32'hFFFF_FFFF >> (8 * L)));
      3'd6: r = (mem << (8 * (3 - L))) | (old & ((32'h1 << (8 * (3 - L))) - 32'h1));
      default: r = mem;
    endcase
    return r;
  endfunction

  // Model of the W slot contents.
  logic        mv, mrw;
  logic [4:0]  mwa;
  logic [1:0]  mws;
  logic [2:0]  mlt;
  logic [31:0] malu, mmem, mold, mpc, mret;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mv = 0; mrw = 0; mwa = 0; mws = 0; mlt = 0;
      malu = 0; mmem = 0; mold = 0; mpc = RST_PC; mret = 0;
    end else begin
      if (mv && (en || flush)) mret = mret + 32'd1;
      if (flush) begin
        mv = 0; mrw = 0;
      end else if (en) begin
        mv = m_valid; mrw = m_regwrite; mwa = m_wa; mws = m_wdsel; mlt = m_ldtype;
        malu = m_alu; mmem = m_mem; mold = m_rt_old; mpc = m_pc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.WE", {31'd0, WE}, {31'd0, mv && mrw && (mwa != 5'd0)});
      chk("m.w_valid", {31'd0, w_valid}, {31'd0, mv});
      chk("m.pc", pc, mpc);
      chk("m.retired", retired, mret);
      if (mv) begin
        chk("m.WA", {27'd0, WA}, {27'd0, mwa});
        chk("m.WD", WD, exp_wd(mws, mlt, malu, mmem, mold, mpc));
      end
    end
  end

  task automatic step(input logic v, input logic rw, input logic [4:0] wa,
                      input logic [1:0] ws, input logic [2:0] lt,
                      input logic [31:0] alu, input logic [31:0] mem,
                      input logic [31:0] old, input logic [31:0] p);
    m_valid = v; m_regwrite = rw; m_wa = wa; m_wdsel = ws; m_ldtype = lt;
    m_alu = alu; m_mem = mem; m_rt_old = old; m_pc = p;
    en = 1'b1; flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0;
    m_valid = 0; m_regwrite = 0; m_wa = 0; m_wdsel = 0; m_ldtype = 0;
    m_alu = 0; m_mem = 0; m_rt_old = 0; m_pc = 0;
    #2 reset = 1'b0;
    #1;
    chk("rst.WE", {31'd0, WE}, 32'd0);
    chk("rst.WA", {27'd0, WA}, 32'd0);
    chk("rst.WD", WD, 32'd0);
    chk("rst.w_valid", {31'd0, w_valid}, 32'd0);
    chk("rst.pc", pc, RST_PC);
    chk("rst.retired", retired, 32'd0);
    chk_en = 1;
    @(posedge clk); #1;
    reset = 1'b1;

    step(1, 1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 32'h100);
    chk("alu.WE", {31'd0, WE}, 32'd1);
    chk("alu.WA", {27'd0, WA}, 32'd5);
    chk("alu.WD", WD, 32'h1234_5678);
    step(1, 1, 5'd0, 2'd0, 3'd0, 32'hCAFE_0000, 32'h0, 32'h0, 32'h104);
    chk("r0.WE", {31'd0, WE}, 32'd0);
    chk("r0.retired", retired, 32'd1);
    step(1, 1, 5'd3, 2'd1, 3'd2, 32'h0000_0002, 32'h8899_AABB, 32'h0, 32'h108);
    chk("r0.retired_next", retired, 32'd2);
    chk("lb", WD, 32'hFFFF_FF99);
    step(1, 1, 5'd3, 2'd1, 3'd1, 32'h0000_0002, 32'h8899_AABB, 32'h0, 32'h10C);
    chk("lbu", WD, 32'h0000_0099);
    step(1, 1, 5'd3, 2'd1, 3'd4, 32'h0000_0002, 32'h8899_AABB, 32'h0, 32'h110);
    chk("lh", WD, 32'hFFFF_8899);
    step(1, 1, 5'd3, 2'd1, 3'd3, 32'h0000_0000, 32'h8899_AABB, 32'h0, 32'h114);
    chk("lhu", WD, 32'h0000_AABB);
    step(1, 1, 5'd4, 2'd1, 3'd6, 32'h0000_0001, 32'h1122_3344, 32'hAABB_CCDD, 32'h118);
    chk("lwl1", WD, 32'h3344_CCDD);
    step(1, 1, 5'd4, 2'd1, 3'd5, 32'h0000_0001, 32'h1122_3344, 32'hAABB_CCDD, 32'h11C);
    chk("lwr1", WD, 32'hAA11_2233);
    step(1, 1, 5'd4, 2'd1, 3'd6, 32'h0000_0003, 32'h1122_3344, 32'hAABB_CCDD, 32'h120);
    chk("lwl3", WD, 32'h1122_3344);
    step(1, 1, 5'd4, 2'd1, 3'd5, 32'h0000_0000, 32'h1122_3344, 32'hAABB_CCDD, 32'h124);
    chk("lwr0", WD, 32'h1122_3344);
    step(1, 1, 5'd31, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    chk("link.wrap", WD, 32'h0000_0004);
    chk("link.pc", pc, 32'hFFFF_FFFC);
    step(1, 1, 5'd7, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0000_3000);
    chk("link", WD, 32'h0000_3008);

    // Stall with changing inputs: W must hold and not count.
    en = 1'b0;
    m_valid = 1; m_regwrite = 1; m_wa = 5'd9; m_wdsel = 2'd0;
    m_alu = 32'h5555_AAAA; m_pc = 32'h4444_0000; m_rt_old = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall.WE", {31'd0, WE}, 32'd1);
      chk("stall.WA", {27'd0, WA}, 32'd7);
      chk("stall.WD", WD, 32'h0000_3008);
      chk("stall.retired", retired, 32'd11);
    end

    // Flush wins over en.
    en = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush.w_valid", {31'd0, w_valid}, 32'd0);
    chk("flush.WE", {31'd0, WE}, 32'd0);
    chk("flush.retired", retired, 32'd12);

    step(1, 1, 5'd9, 2'd0, 3'd0, 32'h0000_DEAD, 32'h0, 32'h0, 32'h200);
    chk("post.WE", {31'd0, WE}, 32'd1);
    chk("post.retired", retired, 32'd12);
    en = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("arst.WE", {31'd0, WE}, 32'd0);
    chk("arst.retired", retired, 32'd0);
    chk("arst.pc", pc, RST_PC);
    chk("arst.w_valid", {31'd0, w_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    step(0, 1, 5'd3, 2'd0, 3'd0, 32'h7777_7777, 32'h0, 32'h0, 32'h300);
    chk("bubble.WE", {31'd0, WE}, 32'd0);
    step(1, 1, 5'd3, 2'd0, 3'd0, 32'h6666_6666, 32'h0, 32'h0, 32'h304);
    chk("bubble.retired", retired, 32'd0);
    chk("after.WD", WD, 32'h6666_6666);
    step(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h308);
    chk("after.retired", retired, 32'd1);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback-stage writer for the register file: the M/W pipeline register plus W-stage result selection.
- Captures memory-stage results on each advancing clock edge.
- Extracts and extends load data, including lwl/lwr merges with the old rt value.
- Drives the register file write port (WA, WD, WE, pc) and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_3000, reset value of the captured PC register.
- LINK_OFFSET, 8, amount added to the PC for link writes (jal/jalr).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- en  in  1  pipeline advance; 0 = stall, hold all W registers.
- flush  in  1  load a bubble into W at the next edge; has priority over en.
- m_valid  in  1  M-stage slot holds a real instruction.
- m_regwrite  in  1  instruction writes the register file.
- m_wa  in  5  destination register.
- m_wdsel  in  2  result source: 0 = ALU, 1 = memory load, 2 = PC+LINK_OFFSET, 3 = ALU.
- m_ldtype  in  3  0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh, 5 lwr, 6 lwl, 7 = lw.
- m_alu  in  32  ALU result / memory byte address.
- m_mem  in  32  aligned data-memory word.
- m_rt_old  in  32  forwarded current rt value, for lwl/lwr.
- m_pc  in  32  instruction PC.
- WA  out  5  write address to the register file.
- WD  out  32  write data to the register file.
- WE  out  1  write enable to the register file.
- pc  out  32  PC of the instruction in W, for the write display.
- w_valid  out  1  W slot holds a real instruction.
- retired  out  32  count of retired instructions.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-stall):
  - valid_r=0, regwrite_r=0, wa_r=0, all data registers 0, pc_r=RESET_PC, retired=0.
  - Resulting outputs: WE=0, WA=0, WD=0, w_valid=0, pc=RESET_PC.
- Rising edge with reset=1:
  - flush=1: valid_r=0, regwrite_r=0; other fields are don't-care.
  - else en=1: all m_* fields are captured.
  - else: all W registers hold their values.
- Latency: M inputs present before edge N appear on WA/WD/WE/pc immediately after edge N.
  - The W-stage datapath from registers to WD is combinational; no extra cycle.
- WE = valid_r & regwrite_r & (wa_r != 0). WA = wa_r. pc = pc_r. w_valid = valid_r.
- WD selection by wdsel_r:
  - 0 or 3: alu_r.
  - 2: pc_r + LINK_OFFSET, modulo 2^32 (wraps).
  - 1: load data as below.
- Load data: L = alu_r[1:0]. Byte k = mem_r[8k+7:8k] (little-endian).
  - lw and type 7: mem_r; L ignored.
  - lbu / lb: byte L, zero- / sign-extended.
  - lhu / lh: halfword mem_r[16*L[1]+15 : 16*L[1]], zero- / sign-extended; L[0] ignored.
  - lwl: L=0 {mem[7:0],old[23:0]}; L=1 {mem[15:0],old[15:0]}; L=2 {mem[23:0],old[7:0]}; L=3 mem.
  - lwr: L=0 mem; L=1 {old[31:24],mem[31:8]}; L=2 {old[31:16],mem[31:16]}; L=3 {old[31:8],mem[31:24]}.
  - old = rt_old_r, captured with the instruction; it is not re-sampled during a stall.
- retired:
  - +1 at an edge where valid_r=1 and (en=1 or flush=1), i.e. the W instruction leaves.
  - Stalls never double-count. Wraps from FFFF_FFFF to 0.
- A stalled W instruction keeps WE asserted every stalled cycle with identical WA/WD, so register file writes are idempotent.
- Bubbles (valid_r=0) never assert WE, whatever regwrite was presented.

Test Plan:
- Reset then release, en=1, m_valid=1, regwrite=1, wa=5, wdsel=0, alu=32'h1234_5678 -> after 1 edge: WE=1, WA=5, WD=32'h1234_5678.
- wa=0, regwrite=1, valid -> WE=0; retired still increments after the next advancing edge.
- wdsel=1, mem=32'h8899_AABB, alu low bits=2:
  - lb -> WD=FFFF_FF99; lbu -> 0000_0099.
  - lh with L=2 -> FFFF_8899; lhu with L=0 -> 0000_AABB.
- mem=32'h1122_3344, old=32'hAABB_CCDD:
  - lwl L=1 -> 3344_CCDD.
  - lwr L=1 -> AA11_2233.
  - lwl L=3 and lwr L=0 -> 1122_3344.
- wdsel=2, pc=32'hFFFF_FFFC -> WD=0000_0004; pc=32'h0000_3000 -> WD=0000_3008.
- Stall 3 cycles with a valid instruction in W, then flush, then drop reset to 0 mid-stall:
  - Outputs are held during the stall and retired does not change.
  - The flush edge gives w_valid=0, WE=0 and retired+1.
  - Asserting reset immediately gives WE=0, retired=0, pc=RESET_PC without waiting for a clock edge.
